// File: rtl/nibble_flag_arbiter.sv
// rtl/nibble_flag_arbiter.sv - round-robin arbiter sharing one 4-bit data >= threshold flag evaluator
module nibble_flag_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [3:0]           cfg_thresh,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_flag,
    input  logic                 rsp_ready,
    output logic                 busy,
    output logic [7:0]           served_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [IDW:0]   LP_NUM  = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LP_LAST = IDW'(NUM_REQ - 1);

    state_t         r_state;
    state_t         w_next;
    logic [IDW-1:0] r_rr_ptr;
    logic [3:0]     r_data_q;
    logic [3:0]     r_thr_q;
    logic [IDW-1:0] r_id_q;
    logic           r_flag_q;
    logic [7:0]     r_served;

    logic [IDW-1:0] w_sel;
    logic           w_found;
    logic           w_accept;
    logic [3:0]     w_data;

    // Search starts one past the last winner and wraps modulo NUM_REQ.
    always_comb begin
        logic [IDW:0] v_cand;
        w_found = 1'b0;
        w_sel   = '0;
        v_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_cand = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (v_cand >= LP_NUM) begin
                v_cand = v_cand - LP_NUM;
            end
            if (!w_found && req_valid[v_cand[IDW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = v_cand[IDW-1:0];
            end
        end
    end

    assign w_accept  = (r_state == ST_IDLE) && w_found;
    assign req_ready = w_accept ? (NUM_REQ'(1) << w_sel) : '0;
    assign w_data    = req_data[{w_sel, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_next = ST_EVAL;
            ST_EVAL:                w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    // Threshold is latched with the data so later cfg changes cannot alter the in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= LP_LAST;
            r_data_q <= 4'd0;
            r_thr_q  <= 4'd0;
            r_id_q   <= '0;
            r_flag_q <= 1'b0;
            r_served <= 8'd0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= w_sel;
                r_data_q <= w_data;
                r_thr_q  <= cfg_thresh;
                r_id_q   <= w_sel;
            end
            if (r_state == ST_EVAL) begin
                r_flag_q <= (r_data_q >= r_thr_q);
            end
            if ((r_state == ST_RESP) && rsp_ready) begin
                r_served <= r_served + 8'd1;
            end
        end
    end

    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_id     = r_id_q;
    assign rsp_flag   = r_flag_q;
    assign busy       = (r_state != ST_IDLE);
    assign served_cnt = r_served;

endmodule

// File: tb/tb_nibble_flag_arbiter.sv
// tb/tb_nibble_flag_arbiter.sv - scoreboard bench for nibble_flag_arbiter
module tb_nibble_flag_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  cfg_thresh;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        rsp_flag;
    logic        rsp_ready;
    logic        busy;
    logic [7:0]  served_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [2:0]  exp_q[$];
    logic [2:0]  mon_e;
    logic [7:0]  exp_served = 8'd0;

    nibble_flag_arbiter #(.NUM_REQ(4), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cfg_thresh(cfg_thresh),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_flag(rsp_flag), .rsp_ready(rsp_ready),
        .busy(busy), .served_cnt(served_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d flag=%0d expected no response", rsp_id, rsp_flag);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id", {30'd0, rsp_id}, {30'd0, mon_e[2:1]});
                chk("rsp_flag", {31'd0, rsp_flag}, {31'd0, mon_e[0]});
            end
            exp_served = exp_served + 8'd1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] ff_flags = 4'b0101;
    logic [3:0] ce_data  [4] = '{4'd0, 4'd15, 4'd14, 4'd15};
    logic [3:0] ce_thr   [4] = '{4'd0, 4'd15, 4'd15, 4'd0};
    logic       ce_flag  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; cfg_thresh = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {28'd0, req_ready}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 0);
        chk("rst_rsp_flag", {31'd0, rsp_flag}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_served", {24'd0, served_cnt}, 0);
        rst_n = 1'b1;
        tick();

        // single request on requester 2
        req_valid = 4'b0100; req_data = 16'h0900; cfg_thresh = 4'd8;
        exp_q.push_back({2'd2, 1'b1});
        #1;
        chk("single_ready", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid = '0;
        chk("single_eval_busy", {31'd0, busy}, 1);
        chk("single_eval_rsp_valid", {31'd0, rsp_valid}, 0);
        tick();
        chk("single_resp_valid", {31'd0, rsp_valid}, 1);
        tick();
        chk("single_served", {24'd0, served_cnt}, 1);
        chk("single_idle", {31'd0, busy}, 0);

        // backpressure with threshold changed after accept
        req_valid = 4'b0010; req_data = 16'h0050; cfg_thresh = 4'd5; rsp_ready = 1'b0;
        exp_q.push_back({2'd1, 1'b1});
        tick();
        req_valid = '0; cfg_thresh = 4'd6;
        tick();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", {31'd0, rsp_valid}, 1);
            chk("bp_id", {30'd0, rsp_id}, 1);
            chk("bp_flag", {31'd0, rsp_flag}, 1);
            chk("bp_req_ready", {28'd0, req_ready}, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        chk("bp_idle", {31'd0, busy}, 0);
        chk("bp_served", {24'd0, served_cnt}, 2);

        // compare edges through requester 1
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0010; req_data = {8'h00, ce_data[i], 4'h0}; cfg_thresh = ce_thr[i];
            exp_q.push_back({2'd1, ce_flag[i]});
            tick();
            req_valid = '0;
            tick();
            tick();
        end
        chk("edges_served", {24'd0, served_cnt}, 6);

        // reset while a response is pending
        req_valid = 4'b1000; req_data = 16'h7000; cfg_thresh = 4'd0; rsp_ready = 1'b0;
        tick();
        req_valid = '0;
        tick();
        chk("mid_rsp_valid_before", {31'd0, rsp_valid}, 1);
        rst_n = 1'b0;
        #1;
        exp_served = 8'd0;
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_served", {24'd0, served_cnt}, 0);
        chk("mid_rst_rsp_id", {30'd0, rsp_id}, 0);
        chk("mid_rst_rsp_flag", {31'd0, rsp_flag}, 0);
        tick();
        rst_n = 1'b1; rsp_ready = 1'b1;

        // fairness with all four requesters valid
        req_valid = 4'b1111; req_data = 16'h3A6C; cfg_thresh = 4'd7;
        for (int g = 0; g < 6; g++) begin
            #1;
            chk("fair_grant", {28'd0, req_ready}, 32'h1 << (g % 4));
            exp_q.push_back({2'(g % 4), ff_flags[g % 4]});
            tick();
            if (g == 5) req_valid = '0;
            chk("fair_eval_ready", {28'd0, req_ready}, 0);
            tick();
            tick();
        end
        chk("fair_served", {24'd0, served_cnt}, {24'd0, exp_served});

        // counter wrap
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_served = 8'd0;
        cfg_thresh = 4'd8;
        for (int k = 1; k <= 257; k++) begin
            logic [3:0] nib;
            nib = 4'(k);
            req_valid = 4'b0100; req_data = {4'h0, nib, 8'h00};
            exp_q.push_back({2'd2, (nib >= 4'd8)});
            tick();
            req_valid = '0;
            tick();
            tick();
            if (k == 256) chk("wrap_256", {24'd0, served_cnt}, 0);
            if (k == 257) chk("wrap_257", {24'd0, served_cnt}, 1);
        end

        tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
